// File: rtl/pc_fetch_if.sv
// IF-stage program counter with redirect/stall handling and a BOOT/RUN/HALT fetch sequencer.
// Define PC_FETCH_BTB_EN to build the direct-mapped branch target buffer for next-PC prediction.
module pc_fetch_if #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter int          BTB_IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubbleF,
  input  logic        br_en,
  input  logic [31:0] br_target,
  input  logic        jmp_en,
  input  logic [31:0] jmp_target,
  input  logic        halt_req,
  input  logic        btb_upd_en,
  input  logic [31:0] btb_upd_pc,
  input  logic [31:0] btb_upd_target,
  input  logic        btb_upd_taken,
  output logic [31:0] PC_IF,
  output logic [29:0] fetch_addr,
  output logic        fetch_valid,
  output logic        halted,
  output logic        pred_taken_IF
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_valid_q, halted_q;
  logic        pred_hit_s;
  logic [31:0] pred_tgt_s;

`ifdef PC_FETCH_BTB_EN
  localparam int TAG_W = 32 - BTB_IDX_W - 2;

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]       btb_tag_q [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q [BTB_ENTRIES];
  logic [1:0]             btb_ctr_q [BTB_ENTRIES];
  logic [BTB_IDX_W-1:0]   lk_idx_s, up_idx_s;
  logic [TAG_W-1:0]       lk_tag_s, up_tag_s;
  logic                   up_match_s;
  logic                   unused_s;

  assign lk_idx_s   = pc_q[BTB_IDX_W+1:2];
  assign lk_tag_s   = pc_q[31:BTB_IDX_W+2];
  assign up_idx_s   = btb_upd_pc[BTB_IDX_W+1:2];
  assign up_tag_s   = btb_upd_pc[31:BTB_IDX_W+2];
  assign up_match_s = btb_valid_q[up_idx_s] && (btb_tag_q[up_idx_s] == up_tag_s);
  assign pred_hit_s = btb_valid_q[lk_idx_s] && (btb_tag_q[lk_idx_s] == lk_tag_s)
                      && btb_ctr_q[lk_idx_s][1];
  assign pred_tgt_s = btb_tgt_q[lk_idx_s];
  assign unused_s   = ^{btb_upd_pc[1:0]};

  // Table update: train a matching entry, or allocate only on a taken outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= 32'h0000_0000;
        btb_ctr_q[i] <= 2'b00;
      end
    end else if (btb_upd_en) begin
      if (up_match_s) begin
        if (btb_upd_taken) begin
          btb_tgt_q[up_idx_s] <= btb_upd_target & WORD_MASK;
          if (btb_ctr_q[up_idx_s] != 2'b11) btb_ctr_q[up_idx_s] <= btb_ctr_q[up_idx_s] + 2'b01;
        end else if (btb_ctr_q[up_idx_s] != 2'b00) begin
          btb_ctr_q[up_idx_s] <= btb_ctr_q[up_idx_s] - 2'b01;
        end
      end else if (btb_upd_taken) begin
        btb_valid_q[up_idx_s] <= 1'b1;
        btb_tag_q[up_idx_s]   <= up_tag_s;
        btb_tgt_q[up_idx_s]   <= btb_upd_target & WORD_MASK;
        btb_ctr_q[up_idx_s]   <= 2'b10;
      end
    end
  end
`else
  logic unused_s;

  assign pred_hit_s = 1'b0;
  assign pred_tgt_s = 32'h0000_0000;
  assign unused_s   = ^{btb_upd_en, btb_upd_pc, btb_upd_target, btb_upd_taken};
`endif

  // Next-PC select and sequencer transitions; redirects win even over a stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (br_en) begin
      pc_d = br_target & WORD_MASK;
    end else if (jmp_en) begin
      pc_d = jmp_target & WORD_MASK;
    end else if (state_q == ST_RUN) begin
      if (bubbleF)         pc_d = pc_q;
      else if (pred_hit_s) pc_d = pred_tgt_s;
      else                 pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    case (state_q)
      ST_BOOT: state_d = halt_req ? ST_HALT : ST_RUN;
      ST_RUN:  state_d = (halt_req && !br_en && !jmp_en) ? ST_HALT : ST_RUN;
      ST_HALT: state_d = halt_req ? ST_HALT : ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // State, PC and status flags; flags track the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= (state_d == ST_RUN);
      halted_q      <= (state_d == ST_HALT);
    end
  end

  assign PC_IF         = pc_q;
  assign fetch_addr    = pc_q[31:2];
  assign fetch_valid   = fetch_valid_q;
  assign halted        = halted_q;
  assign pred_taken_IF = pred_hit_s;

endmodule

// File: tb/tb_pc_fetch_if.sv
// Bench for pc_fetch_if: directed scenarios plus random traffic against a behavioural fetch model.
module tb_pc_fetch_if;

`ifdef PC_FETCH_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bubbleF = 1'b0, br_en = 1'b0, jmp_en = 1'b0, halt_req = 1'b0;
  logic [31:0] br_target = 32'h0, jmp_target = 32'h0;
  logic        btb_upd_en = 1'b0, btb_upd_taken = 1'b0;
  logic [31:0] btb_upd_pc = 32'h0, btb_upd_target = 32'h0;
  logic [31:0] PC_IF;
  logic [29:0] fetch_addr;
  logic        fetch_valid, halted, pred_taken_IF;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=boot, 1=run, 2=halt; BTB keyed by full word address per slot.
  int          m_mode;
  logic [31:0] m_pc;
  bit          m_valid [16];
  logic [29:0] m_word  [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];

  pc_fetch_if #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .bubbleF(bubbleF), .br_en(br_en), .br_target(br_target),
    .jmp_en(jmp_en), .jmp_target(jmp_target), .halt_req(halt_req),
    .btb_upd_en(btb_upd_en), .btb_upd_pc(btb_upd_pc), .btb_upd_target(btb_upd_target),
    .btb_upd_taken(btb_upd_taken), .PC_IF(PC_IF), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .halted(halted), .pred_taken_IF(pred_taken_IF)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pred(input logic [31:0] pc);
    int s;
    s = int'(pc[5:2]);
    return BTB_ON && m_valid[s] && (m_word[s] == pc[31:2]) && (m_ctr[s] >= 2);
  endfunction

  task automatic m_reset();
    m_mode = 0;
    m_pc   = 32'h0000_0100;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_pc"},    PC_IF, m_pc);
    check_eq({tag, "_addr"},  {2'b00, fetch_addr}, {2'b00, m_pc[31:2]});
    check_eq({tag, "_valid"}, {31'd0, fetch_valid}, (m_mode == 1) ? 32'd1 : 32'd0);
    check_eq({tag, "_halt"},  {31'd0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
    check_eq({tag, "_pred"},  {31'd0, pred_taken_IF}, {31'd0, m_pred(m_pc)});
  endtask

  task automatic step(input string tag, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic bub, input logic h,
                      input logic ue, input logic [31:0] upc, input logic [31:0] utg,
                      input logic ut);
    logic [31:0] npc;
    int          nmode, s;
    br_en = b; br_target = bt; jmp_en = j; jmp_target = jt; bubbleF = bub; halt_req = h;
    btb_upd_en = ue; btb_upd_pc = upc; btb_upd_target = utg; btb_upd_taken = ut;
    if (b)                      npc = {bt[31:2], 2'b00};
    else if (j)                 npc = {jt[31:2], 2'b00};
    else if (m_mode != 1 || bub) npc = m_pc;
    else if (m_pred(m_pc))      npc = m_tgt[int'(m_pc[5:2])];
    else                        npc = m_pc + 32'd4;
    if (m_mode == 1) nmode = (h && !b && !j) ? 2 : 1;
    else             nmode = h ? 2 : 1;
    @(posedge clk);
    #1;
    m_pc   = npc;
    m_mode = nmode;
    if (BTB_ON && ue) begin
      s = int'(upc[5:2]);
      if (m_valid[s] && m_word[s] == upc[31:2]) begin
        if (ut) begin
          m_tgt[s] = {utg[31:2], 2'b00};
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[s] = 1'b1;
        m_word[s]  = upc[31:2];
        m_tgt[s]   = {utg[31:2], 2'b00};
        m_ctr[s]   = 2;
      end
    end
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic jump(input string tag, input logic [31:0] t);
    step(tag, 1'b0, 32'h0, 1'b1, t, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic        r_halt;
    logic [31:0] r_bt, r_jt, r_upc;
    m_reset();

    // Reset values while rst is held, then the BOOT cycle, then sequential fetch.
    #12;
    check_eq("rst_pc", PC_IF, 32'h0000_0100);
    check_eq("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check_eq("rst_halt", {31'd0, halted}, 32'd0);
    check_eq("rst_pred", {31'd0, pred_taken_IF}, 32'd0);
    #5 rst = 1'b0;
    check_all("boot");
    idle("t1a"); check_eq("t1_pc0", PC_IF, 32'h0000_0100);
    idle("t1b"); check_eq("t1_pc1", PC_IF, 32'h0000_0104);
    idle("t1c"); check_eq("t1_pc2", PC_IF, 32'h0000_0108);

    // Stall holds PC, then advance.
    for (int i = 0; i < 3; i++) begin
      step("t2_hold", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      check_eq("t2_held", PC_IF, 32'h0000_0108);
    end
    idle("t2_go"); check_eq("t2_next", PC_IF, 32'h0000_010C);

    // Redirect priority and target alignment.
    step("t3_pri", 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 1'b1, 1'b0,
         1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("t3_br", PC_IF, 32'h0000_0200);
    jump("t3_jmp", 32'h0000_0303);
    check_eq("t3_align", PC_IF, 32'h0000_0300);

    // Halt entry, hold, release, and reset from HALT.
    jump("t4_to140", 32'h0000_0140);
    step("t4_halt", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("t4_halted", {31'd0, halted}, 32'd1);
    check_eq("t4_hpc", PC_IF, 32'h0000_0144);
    step("t4_hold", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    idle("t4_rel");
    check_eq("t4_resume", PC_IF, 32'h0000_0144);
    check_eq("t4_rvalid", {31'd0, fetch_valid}, 32'd1);
    idle("t4_next"); check_eq("t4_148", PC_IF, 32'h0000_0148);
    step("t4_halt2", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    halt_req = 1'b0;
    rst = 1'b1;
    #2;
    m_reset();
    check_all("t4_rst");
    #2 rst = 1'b0;
    idle("t4_boot");

    // PC+4 wraps past the top of the address space.
    jump("t5_top", 32'hFFFF_FFFC);
    idle("t5_wrap"); check_eq("t5_zero", PC_IF, 32'h0000_0000);

    // Two taken trainings then a fetch of the trained PC.
    step("t6_u1", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0120, 32'h0000_0400, 1'b1);
    step("t6_u2", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0120, 32'h0000_0400, 1'b1);
    jump("t6_fetch", 32'h0000_0120);
    check_eq("t6_pred", {31'd0, pred_taken_IF}, BTB_ON ? 32'd1 : 32'd0);
    idle("t6_next");
    check_eq("t6_npc", PC_IF, BTB_ON ? 32'h0000_0400 : 32'h0000_0124);

    // Random traffic in a small PC window so BTB hits and aliasing occur.
    r_halt = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) r_halt = ~r_halt;
      r_bt  = 32'h0000_0100 + ({27'd0, 5'($urandom_range(0, 31))} << 2) + 32'($urandom_range(0, 3));
      r_jt  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF8
              : 32'h0000_0100 + ({27'd0, 5'($urandom_range(0, 31))} << 2);
      r_upc = 32'h0000_0100 + ({27'd0, 5'($urandom_range(0, 31))} << 2);
      step("rnd", 1'($urandom_range(0, 9) == 0), r_bt, 1'($urandom_range(0, 9) == 0), r_jt,
           1'($urandom_range(0, 4) == 0), r_halt, 1'($urandom_range(0, 2) == 0), r_upc,
           32'h0000_0100 + ({27'd0, 5'($urandom_range(0, 31))} << 2),
           1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
